// File: rtl/gmii_speed_pkg.sv
// Shared encodings, FSM state type and speed helpers for the GMII/MII link-speed controller.
package gmii_speed_pkg;

   localparam logic [1:0] SPD_10   = 2'b00;
   localparam logic [1:0] SPD_100  = 2'b01;
   localparam logic [1:0] SPD_1000 = 2'b10;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_GATE_OFF = 2'd1,
      ST_SELECT   = 2'd2,
      ST_GATE_ON  = 2'd3
   } sw_state_t;

   // Encodings are ordered by rate; 2'b11 folds onto 1000.
   function automatic logic [1:0] spd_norm(input logic [1:0] s);
      return (s == 2'b11) ? SPD_1000 : s;
   endfunction

   function automatic logic spd_lt(input logic [1:0] a, input logic [1:0] b);
      return spd_norm(a) < spd_norm(b);
   endfunction

endpackage

// File: rtl/sync_ff.sv
// Single-bit multi-flop synchroniser for an asynchronous level input.
module sync_ff #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] chain;

   always_ff @(posedge clk) begin
      if (!rst_n) chain <= '0;
      else        chain <= {chain[STAGES-2:0], d};
   end

   assign q = chain[STAGES-1];

endmodule

// File: rtl/gmii_speed_ctrl.sv
// Resolves the GMII/MII link speed from PHY indicators and sequences the
// downstream glitch-free TX clock mux through a gated select change.
module gmii_speed_ctrl
   import gmii_speed_pkg::*;
#(
   parameter int HOLD_CYCLES  = 16777215,
   parameter int GUARD_CYCLES = 8,
   parameter int SYNC_STAGES  = 2
) (
   input  logic       SYS_CLK,
   input  logic       SYS_RST_N,
   input  logic       GE_IND,
   input  logic       FE_IND,
   input  logic       FORCE_EN,
   input  logic [1:0] FORCE_SPEED,
   output logic [1:0] CLK_SEL,
   output logic       CLK_GATE_EN,
   output logic [1:0] SPEED,
   output logic       SPEED_CHG,
   output logic       SWITCHING,
   output logic       LINK_GE
);

   localparam int TMR_W = (HOLD_CYCLES  > 1) ? $clog2(HOLD_CYCLES)  : 1;
   localparam int GRD_W = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(HOLD_CYCLES - 1);
   localparam logic [GRD_W-1:0] GRD_LAST = GRD_W'(GUARD_CYCLES - 1);

   logic             ge_s;
   logic             fe_s;
   logic [1:0]       cand;
   logic             is_run;
   logic             lower;
   logic             dn_due;
   logic             req;
   logic [TMR_W-1:0] hold_tmr;
   logic [GRD_W-1:0] guard_cnt;
   logic [1:0]       target;
   sw_state_t        state;

   sync_ff #(.STAGES(SYNC_STAGES)) u_sync_ge (
      .clk   (SYS_CLK),
      .rst_n (SYS_RST_N),
      .d     (GE_IND),
      .q     (ge_s)
   );

   sync_ff #(.STAGES(SYNC_STAGES)) u_sync_fe (
      .clk   (SYS_CLK),
      .rst_n (SYS_RST_N),
      .d     (FE_IND),
      .q     (fe_s)
   );

   always_comb begin
      cand = SPD_10;
      if (FORCE_EN)  cand = spd_norm(FORCE_SPEED);
      else if (ge_s) cand = SPD_1000;
      else if (fe_s) cand = SPD_100;
   end

   // Upgrades and overrides act at once; only unforced downgrades wait out the timer.
   assign is_run = (state == ST_RUN);
   assign lower  = spd_lt(cand, SPEED);
   assign dn_due = is_run && !FORCE_EN && lower && (hold_tmr == TMR_LAST);
   assign req    = is_run && (spd_lt(SPEED, cand) || (FORCE_EN && (cand != SPEED)) || dn_due);

   always_ff @(posedge SYS_CLK) begin
      if (!SYS_RST_N || !is_run || FORCE_EN || !lower || dn_due)
         hold_tmr <= '0;
      else
         hold_tmr <= hold_tmr + TMR_W'(1);
   end

   always_ff @(posedge SYS_CLK) begin
      if (!SYS_RST_N) begin
         state       <= ST_SELECT;
         guard_cnt   <= '0;
         target      <= SPD_1000;
         CLK_SEL     <= SPD_1000;
         SPEED       <= SPD_1000;
         CLK_GATE_EN <= 1'b0;
         SWITCHING   <= 1'b1;
         SPEED_CHG   <= 1'b0;
         LINK_GE     <= 1'b1;
      end else begin
         SPEED_CHG <= 1'b0;
         case (state)
            ST_RUN: begin
               if (req) begin
                  state       <= ST_GATE_OFF;
                  guard_cnt   <= '0;
                  target      <= cand;
                  CLK_GATE_EN <= 1'b0;
                  SWITCHING   <= 1'b1;
               end
            end
            ST_GATE_OFF: begin
               if (guard_cnt == GRD_LAST) begin
                  state     <= ST_SELECT;
                  guard_cnt <= '0;
                  CLK_SEL   <= target;
                  SPEED     <= target;
                  LINK_GE   <= (target == SPD_1000);
               end else begin
                  guard_cnt <= guard_cnt + GRD_W'(1);
               end
            end
            ST_SELECT: begin
               if (guard_cnt == GRD_LAST) begin
                  state       <= ST_GATE_ON;
                  guard_cnt   <= '0;
                  CLK_GATE_EN <= 1'b1;
                  SWITCHING   <= 1'b0;
                  SPEED_CHG   <= 1'b1;
               end else begin
                  guard_cnt <= guard_cnt + GRD_W'(1);
               end
            end
            ST_GATE_ON: state <= ST_RUN;
            default:    state <= ST_RUN;
         endcase
      end
   end

endmodule
